// File: rtl/riscv_cmp_pkg.sv
// Purpose : shared funct3 encodings, FSM state type and decode helpers for the branch comparator.
// Latency : n/a (declarations and pure functions only).
// Backpressure: n/a.
package riscv_cmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // BLT/BGE compare as two's complement; everything else is unsigned.
    function automatic logic is_signed_f3(input logic [2:0] f3);
        return (f3 == F3_BLT) || (f3 == F3_BGE);
    endfunction

    // 010 and 011 are the only unused branch encodings.
    function automatic logic is_legal_f3(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic logic branch_result_f(input logic [2:0] f3,
                                             input logic       eq,
                                             input logic       lt);
        logic res;
        res = 1'b0;
        case (f3)
            F3_BEQ:          res = eq;
            F3_BNE:          res = !eq;
            F3_BLT, F3_BLTU: res = lt;
            F3_BGE, F3_BGEU: res = !lt;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_cmp_chunk.sv
// Purpose : compare one CHUNK_W slice of two operands, optionally flipping the slice MSB.
// Latency : combinational.
// Backpressure: none (no handshake).
// Ports: i_a/i_b slices, i_flip_msb turns the unsigned compare into a signed one on the
//        top slice, o_neq = slices differ, o_lt = (a < b) unsigned after the flip.
module riscv_cmp_chunk #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_flip_msb,
    output logic               o_neq,
    output logic               o_lt
);

    logic [CHUNK_W-1:0] w_mask;
    logic [CHUNK_W-1:0] w_a;
    logic [CHUNK_W-1:0] w_b;

    // Inverting the sign bit of both operands maps two's complement order onto unsigned order.
    assign w_mask = CHUNK_W'(i_flip_msb) << (CHUNK_W - 1);
    assign w_a    = i_a ^ w_mask;
    assign w_b    = i_b ^ w_mask;

    assign o_neq  = (w_a != w_b);
    assign o_lt   = (w_a < w_b);

endmodule

// File: rtl/riscv_branch_cmp_seq.sv
// Purpose : multi-cycle RISC-V branch comparator scanning CHUNK_W slices MSB-first.
// Latency : N = DATA_W/CHUNK_W cycles worst case from accept, N-k with early exit, 1 for illegal funct3.
// Backpressure: result held frozen in DONE until out_ready; in_ready only while IDLE.
// Ports: clk/rst (sync, active-high), flush kills the current op; in_valid/in_ready with
//        funct3/rs1/rs2; out_valid/out_ready with result, eq, lt, illegal.
module riscv_branch_cmp_seq
    import riscv_cmp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CHUNK_W    = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              result,
    output logic              eq,
    output logic              lt,
    output logic              illegal
);

    localparam int             N     = DATA_W / CHUNK_W;
    localparam int             KW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]  K_MAX = KW'(N - 1);

    cmp_state_e        r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_f3;
    logic [KW-1:0]     r_k;
    logic              r_decided;
    logic              r_out_valid;
    logic              r_result;
    logic              r_eq;
    logic              r_lt;
    logic              r_illegal;

    logic [CHUNK_W-1:0] w_a_chunk;
    logic [CHUNK_W-1:0] w_b_chunk;
    logic               w_flip;
    logic               w_neq;
    logic               w_lt;
    logic               w_full_eq;
    logic               w_full_lt;
    logic               w_dec_nxt;
    logic               w_lt_nxt;
    logic               w_fin;
    logic               w_res_nxt;

    assign w_a_chunk = r_a[int'(r_k)*CHUNK_W +: CHUNK_W];
    assign w_b_chunk = r_b[int'(r_k)*CHUNK_W +: CHUNK_W];
    assign w_flip    = is_signed_f3(r_f3) && (r_k == K_MAX);

    riscv_cmp_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk (
        .i_a        (w_a_chunk),
        .i_b        (w_b_chunk),
        .i_flip_msb (w_flip),
        .o_neq      (w_neq),
        .o_lt       (w_lt)
    );

    // Illegal ops still report eq/lt but finish after one BUSY cycle, so they
    // are resolved with a full-width unsigned compare instead of the chunk scan.
    assign w_full_eq = (r_a == r_b);
    assign w_full_lt = (r_a < r_b);

    always_comb begin
        w_dec_nxt = 1'b0;
        w_lt_nxt  = 1'b0;
        w_fin     = 1'b0;
        w_res_nxt = 1'b0;
        if (r_illegal) begin
            w_dec_nxt = !w_full_eq;
            w_lt_nxt  = w_full_lt;
            w_fin     = 1'b1;
            w_res_nxt = 1'b0;
        end else begin
            // Once a higher chunk has differed, lower chunks cannot change the order.
            w_dec_nxt = r_decided | w_neq;
            w_lt_nxt  = r_decided ? r_lt : (w_neq & w_lt);
            w_fin     = (r_k == '0) || (EARLY_EXIT && w_neq);
            w_res_nxt = branch_result_f(r_f3, !w_dec_nxt, w_lt_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_f3        <= '0;
            r_k         <= '0;
            r_decided   <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a       <= rs1;
                        r_b       <= rs2;
                        r_f3      <= funct3;
                        r_k       <= K_MAX;
                        r_decided <= 1'b0;
                        r_result  <= 1'b0;
                        r_eq      <= 1'b0;
                        r_lt      <= 1'b0;
                        r_illegal <= !is_legal_f3(funct3);
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    r_decided <= w_dec_nxt;
                    r_lt      <= w_lt_nxt;
                    if (w_fin) begin
                        r_eq        <= !w_dec_nxt;
                        r_result    <= w_res_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k - KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_riscv_branch_cmp_seq.sv
// Purpose : directed self-checking bench for riscv_branch_cmp_seq (fixed-latency and early-exit builds).
// Latency : counts clock edges from the accept edge to out_valid.
// Backpressure: exercises out_ready held low and flush/reset mid-operation.
module tb_riscv_branch_cmp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_ready;
    logic        sel;      // 0 = fixed-latency instance, 1 = early-exit instance

    logic iv0, iv1;
    logic ir0, ir1, ov0, ov1, res0, res1, eq0, eq1, lt0, lt1, il0, il1;
    logic in_ready, out_valid, result, eq, lt, illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign iv0 = in_valid && !sel;
    assign iv1 = in_valid &&  sel;

    riscv_branch_cmp_seq #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b0)) u_dut_fix (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .out_valid(ov0), .out_ready(out_ready),
        .result(res0), .eq(eq0), .lt(lt0), .illegal(il0)
    );

    riscv_branch_cmp_seq #(.DATA_W(32), .CHUNK_W(8), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .out_valid(ov1), .out_ready(out_ready),
        .result(res1), .eq(eq1), .lt(lt1), .illegal(il1)
    );

    assign in_ready  = sel ? ir1  : ir0;
    assign out_valid = sel ? ov1  : ov0;
    assign result    = sel ? res1 : res0;
    assign eq        = sel ? eq1  : eq0;
    assign lt        = sel ? lt1  : lt0;
    assign illegal   = sel ? il1  : il0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".in_ready"},  in_ready,  1);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".result"},    result,    0);
        chk({tag, ".eq"},        eq,        0);
        chk({tag, ".lt"},        lt,        0);
        chk({tag, ".illegal"},   illegal,   0);
    endtask

    // Issue one op, measure accept-to-out_valid latency, check the result,
    // optionally hold out_ready low for 'hold' cycles, then retire it.
    task automatic run_op(input string tag, input logic s, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic e_res, input logic e_eq,
                          input logic e_lt, input logic e_ill, input int hold);
        int   lat;
        logic h_res, h_eq, h_lt;
        sel      = s;
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        #1;
        chk({tag, ".accept_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"},  lat,      exp_lat);
        chk({tag, ".result"},   result,   e_res);
        chk({tag, ".eq"},       eq,       e_eq);
        chk({tag, ".lt"},       lt,       e_lt);
        chk({tag, ".illegal"},  illegal,  e_ill);
        chk({tag, ".busy_rdy"}, in_ready, 0);
        if (hold > 0) begin
            h_res = result;
            h_eq  = eq;
            h_lt  = lt;
            // Offer a different op while stalled: it must not be taken.
            in_valid = 1'b1;
            rs1      = ~a;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, ".hold_vld"}, out_valid, 1);
                chk({tag, ".hold_res"}, {h_res, h_eq, h_lt}, {result, eq, lt});
                chk({tag, ".hold_rdy"}, in_ready, 0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, ".retire_vld"}, out_valid, 0);
        chk({tag, ".retire_rdy"}, in_ready,  1);
    endtask

    initial begin : stim
        logic seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        funct3    = 3'b000;
        rs1       = '0;
        rs2       = '0;
        out_ready = 1'b0;
        sel       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst_fix");
        sel = 1'b1; #1;
        chk_reset_vals("rst_ee");
        rst = 1'b0;
        @(posedge clk); #1;

        // Fixed-latency build: always 4 cycles.
        run_op("blt_neg",  1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 4, 1, 0, 1, 0, 0);
        run_op("bge_eq",   1'b0, 3'b101, 32'h8000_0000, 32'h8000_0000, 4, 1, 1, 0, 0, 0);
        run_op("bltu_msb", 1'b0, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 4, 0, 0, 0, 0, 0);

        // Early-exit build: latency follows the first differing chunk.
        run_op("bne_ee",   1'b1, 3'b001, 32'h1200_0000, 32'h1300_0000, 1, 1, 0, 1, 0, 0);
        run_op("beq_ee",   1'b1, 3'b000, 32'h0000_0001, 32'h0000_0000, 4, 0, 0, 0, 0, 0);
        run_op("bge_sgn",  1'b1, 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 1, 1, 0, 0, 0, 0);
        run_op("illegal",  1'b1, 3'b010, 32'h0000_0005, 32'h0000_0005, 1, 0, 1, 0, 1, 0);

        // Backpressure: out_ready low for 5 cycles after out_valid.
        run_op("bp",       1'b1, 3'b110, 32'h0000_0005, 32'h0000_0009, 4, 1, 0, 1, 0, 5);

        // Flush in the second BUSY cycle.
        sel = 1'b0; funct3 = 3'b100; rs1 = 32'h1; rs2 = 32'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = out_valid;
        @(posedge clk); #1;
        seen = seen | out_valid;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.rdy", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        chk("flush.no_vld", seen, 0);

        run_op("bgeu_post", 1'b0, 3'b111, 32'h0000_0010, 32'h0000_0020, 4, 0, 0, 1, 0, 0);

        // Reset in the middle of BUSY.
        sel = 1'b0; funct3 = 3'b010; rs1 = 32'h3; rs2 = 32'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rstmid.busy", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_vals("rstmid");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
